// File: rtl/opencl_result_collector_pkg.sv
// Shared definitions for the multi-channel OpenCL result collector.
//   clog2     : ceiling log2 for elaboration-time width math
//   chanIdxW  : width of a channel index, never below one bit
//   MODE_ANY / MODE_ORDERED : values of the ORDERED parameter
package opencl_result_collector_pkg;

  localparam int MODE_ANY     = 0;
  localparam int MODE_ORDERED = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // A single channel still needs a one-bit chanOut.
  function automatic int chanIdxW(input int numChannels);
    return (clog2(numChannels) < 1) ? 1 : clog2(numChannels);
  endfunction

endpackage

// File: rtl/opencl_result_collector_fifo.sv
// result_fifo: synchronous first-word-fall-through FIFO for one channel.
//   clock, resetn : clock and synchronous active-low reset
//   push/pushData : write request; accepted when not full, or when full
//                   and popped in the same cycle
//   pop/popData   : popData always shows the head word; pop consumes it
//   empty, full   : occupancy flags
//   count         : occupancy 0..DEPTH inclusive
module result_fifo
  import opencl_result_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       pushData,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       popData,
  output logic                        empty,
  output logic                        full,
  output logic [clog2(DEPTH):0]       count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wrPtr;
  logic [AW-1:0]         rdPtr;
  logic                  doWrite;
  logic                  doRead;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign doWrite = push && (!full || pop);
  assign doRead  = pop && !empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + AW'(1);
      if (doRead)  rdPtr <= rdPtr + AW'(1);
      if (doWrite && !doRead)      count <= count + CW'(1);
      else if (!doWrite && doRead) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; pointers define what is valid.
  always_ff @(posedge clock) begin
    if (resetn && doWrite) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/opencl_result_collector.sv
// opencl_result_collector: merges NUM_CHANNELS pipeline result streams onto
// one OpenCL output stream.
//   clock, resetn : clock and synchronous active-low reset
//   chanValid     : per-channel result strobe, no backpressure (always absorbed)
//   chanData      : channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   slowChannel   : per-channel throttle request, occupancy >= DEPTH-SLOW_MARGIN
//   iready/ovalid : output handshake; a word transfers on a rising edge where
//                   ovalid && iready. While ovalid && !iready, dataOut and
//                   chanOut hold stable. ovalid never depends on iready.
//   dataOut       : output word, unmodified from the channel
//   chanOut       : source channel of dataOut
//   overflow      : sticky per channel, set when a push hit a full FIFO
// ORDERED=MODE_ORDERED pops only the channel under a rotating order pointer
// (head-of-line blocking is intended); MODE_ANY round-robins non-empty FIFOs.
module opencl_result_collector
  import opencl_result_collector_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 32,
  parameter int SLOW_MARGIN  = 6,
  parameter int ORDERED      = 1
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic [NUM_CHANNELS-1:0]            chanValid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] chanData,
  output logic [NUM_CHANNELS-1:0]            slowChannel,
  input  logic                               iready,
  output logic                               ovalid,
  output logic [DATA_WIDTH-1:0]              dataOut,
  output logic [chanIdxW(NUM_CHANNELS)-1:0]  chanOut,
  output logic [NUM_CHANNELS-1:0]            overflow
);

  localparam int CIW = chanIdxW(NUM_CHANNELS);
  localparam int CW  = clog2(DEPTH) + 1;

  logic [NUM_CHANNELS-1:0] fifoEmpty;
  logic [NUM_CHANNELS-1:0] fifoFull;
  logic [NUM_CHANNELS-1:0] fifoPop;
  logic [CW-1:0]           fifoCount [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   fifoData  [NUM_CHANNELS];

  logic [CIW-1:0] orderPtr;
  logic [CIW-1:0] lastGrant;
  logic [CIW-1:0] selChan;
  logic [CIW-1:0] arbChan;
  logic           selValid;
  logic           loadEn;
  logic           doPop;
  int             arbIdx;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : gChan
    result_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) uFifo (
      .clock   (clock),
      .resetn  (resetn),
      .push    (chanValid[g]),
      .pushData(chanData[g*DATA_WIDTH +: DATA_WIDTH]),
      .pop     (fifoPop[g]),
      .popData (fifoData[g]),
      .empty   (fifoEmpty[g]),
      .full    (fifoFull[g]),
      .count   (fifoCount[g])
    );

    assign slowChannel[g] = (int'(fifoCount[g]) >= (DEPTH - SLOW_MARGIN));
  end

  // Channel selection; a pop happens only when the output register can load.
  always_comb begin
    loadEn   = !ovalid || iready;
    selValid = 1'b0;
    selChan  = '0;
    arbChan  = '0;
    arbIdx   = 0;
    if (ORDERED == MODE_ORDERED) begin
      selChan  = orderPtr;
      selValid = !fifoEmpty[orderPtr];
    end else begin
      // Search starts at the channel after the last grant.
      for (int k = 1; k <= NUM_CHANNELS; k++) begin
        arbIdx = int'(lastGrant) + k;
        if (arbIdx >= NUM_CHANNELS) arbIdx = arbIdx - NUM_CHANNELS;
        arbChan = CIW'(arbIdx);
        if (!selValid && !fifoEmpty[arbChan]) begin
          selValid = 1'b1;
          selChan  = arbChan;
        end
      end
    end
    doPop   = loadEn && selValid;
    fifoPop = '0;
    if (doPop) fifoPop[selChan] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ovalid    <= 1'b0;
      dataOut   <= '0;
      chanOut   <= '0;
      orderPtr  <= '0;
      lastGrant <= CIW'(NUM_CHANNELS - 1);
      overflow  <= '0;
    end else begin
      overflow <= overflow | (chanValid & fifoFull & ~fifoPop);
      if (loadEn) begin
        ovalid <= selValid;
        if (selValid) begin
          dataOut <= fifoData[selChan];
          chanOut <= selChan;
        end
      end
      if (doPop) begin
        if (ORDERED == MODE_ORDERED) begin
          orderPtr <= (orderPtr == CIW'(NUM_CHANNELS - 1)) ? '0 : orderPtr + CIW'(1);
        end else begin
          lastGrant <= selChan;
        end
      end
    end
  end

endmodule

// File: tb/tb_opencl_result_collector.sv
module tb_opencl_result_collector;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 32;
  localparam int SM    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // Ordered instance
  logic [N-1:0]    chan_valid;
  logic [N*DW-1:0] chan_data;
  logic            iready;
  logic [N-1:0]    slow;
  logic [N-1:0]    ovf;
  logic            ovalid;
  logic [DW-1:0]   data_out;
  logic [1:0]      chan_out;

  // Any-order instance
  logic [N-1:0]    chan_valid_a;
  logic [N*DW-1:0] chan_data_a;
  logic            iready_a;
  logic [N-1:0]    slow_a;
  logic [N-1:0]    ovf_a;
  logic            ovalid_a;
  logic [DW-1:0]   data_out_a;
  logic [1:0]      chan_out_a;

  opencl_result_collector #(
    .NUM_CHANNELS(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SLOW_MARGIN(SM), .ORDERED(1)
  ) dut (
    .clock(clk), .resetn(resetn), .chanValid(chan_valid), .chanData(chan_data),
    .slowChannel(slow), .iready(iready), .ovalid(ovalid), .dataOut(data_out),
    .chanOut(chan_out), .overflow(ovf)
  );

  opencl_result_collector #(
    .NUM_CHANNELS(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SLOW_MARGIN(SM), .ORDERED(0)
  ) dut_any (
    .clock(clk), .resetn(resetn), .chanValid(chan_valid_a), .chanData(chan_data_a),
    .slowChannel(slow_a), .iready(iready_a), .ovalid(ovalid_a), .dataOut(data_out_a),
    .chanOut(chan_out_a), .overflow(ovf_a)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected {chan, data} in output order, one queue per instance
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] exp_qa[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_qa.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_remaining", 128'(exp_q.size() + exp_qa.size()), 128'(0));
    repeat (2) tick();
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, 32'($urandom_range(0, 32'hffff_fffe))};
  endfunction

  // Ordered-instance monitor: output order, data integrity and stall hold
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_chan;
  int            first_ov_cyc = -1;
  logic [DW+1:0] mon_e;

  always @(negedge clk) begin
    if (resetn) begin
      if (prev_stall) begin
        chk("hold_valid", 128'(ovalid), 128'(1));
        chk("hold_data", 128'(data_out), 128'(prev_data));
        chk("hold_chan", 128'(chan_out), 128'(prev_chan));
      end
      if (ovalid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (ovalid && iready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 128'(exp_q.size()), 128'(1));
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_chan", 128'(chan_out), 128'(mon_e[DW+1:DW]));
          chk("out_data", 128'(data_out), 128'(mon_e[DW-1:0]));
        end
      end
      prev_stall = ovalid && !iready;
      prev_data  = data_out;
      prev_chan  = chan_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Any-order monitor
  logic          prev_stall_a = 1'b0;
  logic [DW-1:0] prev_data_a;
  logic [DW+1:0] mon_ea;
  int            gcount [N];

  initial for (int i = 0; i < N; i++) gcount[i] = 0;

  always @(negedge clk) begin
    if (resetn) begin
      if (prev_stall_a) begin
        chk("any_hold_valid", 128'(ovalid_a), 128'(1));
        chk("any_hold_data", 128'(data_out_a), 128'(prev_data_a));
      end
      if (ovalid_a && iready_a) begin
        gcount[chan_out_a] = gcount[chan_out_a] + 1;
        if (exp_qa.size() == 0) begin
          chk("any_out_unexpected", 128'(exp_qa.size()), 128'(1));
        end else begin
          mon_ea = exp_qa.pop_front();
          chk("any_out_chan", 128'(chan_out_a), 128'(mon_ea[DW+1:DW]));
          chk("any_out_data", 128'(data_out_a), 128'(mon_ea[DW-1:0]));
        end
      end
      prev_stall_a = ovalid_a && !iready_a;
      prev_data_a  = data_out_a;
    end else begin
      prev_stall_a = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int            ord [4];
    logic [DW-1:0] wd [N][2];
    logic [DW-1:0] w;
    logic [DW-1:0] held;
    int            ch0_cyc;
    int            c;

    ord = '{3, 1, 0, 2};
    ch0_cyc = 0;

    // ---- Reset with all channels strobing ----
    resetn = 1'b0;
    chan_valid = '1;
    chan_valid_a = '1;
    chan_data = {4{rnd_word()}};
    chan_data_a = {4{rnd_word()}};
    iready = 1'b1;
    iready_a = 1'b1;
    repeat (3) tick();
    chk("rst_ovalid", 128'(ovalid), 128'(0));
    chk("rst_slow", 128'(slow), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    chk("rst_data", 128'(data_out), 128'(0));
    chk("rst_chan", 128'(chan_out), 128'(0));
    chk("rst_any_ovalid", 128'(ovalid_a), 128'(0));
    chk("rst_any_ovf", 128'(ovf_a), 128'(0));
    resetn = 1'b1;
    chan_valid = '0;
    chan_valid_a = '0;
    repeat (5) begin
      tick();
      chk("rst_nothing_kept", 128'(ovalid), 128'(0));
      chk("rst_any_nothing_kept", 128'(ovalid_a), 128'(0));
    end

    // ---- Ordered merge: pushes ch3,ch1,ch0,ch2 twice ----
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < N; j++) wd[j][k] = rnd_word();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < N; j++) exp_q.push_back({2'(j), wd[j][k]});
    first_ov_cyc = -1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        c = ord[j];
        chan_valid = 4'(1 << c);
        chan_data = '0;
        chan_data[c*DW +: DW] = wd[c][k];
        if (k == 0 && c == 0) ch0_cyc = cyc;
        tick();
      end
    end
    chan_valid = '0;
    wait_drain();
    chk("first_latency", 128'(first_ov_cyc), 128'(ch0_cyc + 2));

    // ---- Head-of-line blocking: ch1, ch2 filled, pointer at 0 ----
    w = rnd_word();
    exp_q.push_back({2'd0, w});
    chan_data = '0;
    chan_data[1*DW +: DW] = rnd_word();
    chan_data[2*DW +: DW] = rnd_word();
    exp_q.push_back({2'd1, chan_data[1*DW +: DW]});
    exp_q.push_back({2'd2, chan_data[2*DW +: DW]});
    chan_valid = 4'b0110;
    tick();
    chan_valid = '0;
    repeat (8) begin
      tick();
      chk("hol_blocked", 128'(ovalid), 128'(0));
    end
    chan_data = '0;
    chan_data[0 +: DW] = w;
    chan_valid = 4'b0001;
    tick();
    chan_valid = '0;
    wait_drain();

    // ---- Backpressure, throttle and overflow on ch2 (pointer now at 3) ----
    iready = 1'b0;
    held = data_out;
    for (int k = 1; k <= 33; k++) begin
      chan_data = '0;
      chan_data[2*DW +: DW] = rnd_word();
      chan_valid = 4'b0100;
      tick();
      if (k == 25) chk("slow_below", 128'(slow), 128'(4'b0000));
      if (k == 26) chk("slow_rise", 128'(slow), 128'(4'b0100));
      if (k == 32) chk("full_no_ovf", 128'(ovf), 128'(4'b0000));
      if (k == 33) chk("ovf_set", 128'(ovf), 128'(4'b0100));
    end
    chan_valid = '0;
    tick();
    chk("stall_ovalid", 128'(ovalid), 128'(0));
    chk("stall_data", 128'(data_out), 128'(held));
    chk("ovf_sticky", 128'(ovf), 128'(4'b0100));

    // ---- Reset mid-transfer discards buffered words ----
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    iready = 1'b1;
    repeat (5) begin
      tick();
      chk("rst2_discard", 128'(ovalid), 128'(0));
    end
    chk("rst2_ovf", 128'(ovf), 128'(0));
    chk("rst2_slow", 128'(slow), 128'(0));

    // ---- Stall/hold: 200 words with iready toggling ----
    for (int k = 0; k < 200; k++) begin
      c = k % N;
      w = rnd_word();
      exp_q.push_back({2'(c), w});
      chan_data = '0;
      chan_data[c*DW +: DW] = w;
      chan_valid = 4'(1 << c);
      iready = ~iready;
      tick();
      chan_valid = '0;
      iready = ~iready;
      tick();
    end
    iready = 1'b1;
    wait_drain();
    chk("stall_no_ovf", 128'(ovf), 128'(0));

    // ---- Any-order fairness: all channels valid for 25 cycles ----
    for (int t = 0; t < 25; t++) begin
      chan_valid_a = '1;
      for (int j = 0; j < N; j++) begin
        w = rnd_word();
        chan_data_a[j*DW +: DW] = w;
        exp_qa.push_back({2'(j), w});
      end
      tick();
    end
    chan_valid_a = '0;
    wait_drain();
    for (int j = 0; j < N; j++) chk("fair_count", 128'(gcount[j]), 128'(25));
    chk("fair_no_ovf", 128'(ovf_a), 128'(0));

    // ---- Any-order: push and pop on a full FIFO ----
    iready_a = 1'b0;
    for (int k = 0; k < 33; k++) begin
      w = rnd_word();
      chan_data_a = '0;
      chan_data_a[0 +: DW] = w;
      chan_valid_a = 4'b0001;
      exp_qa.push_back({2'd0, w});
      tick();
    end
    chk("any_full_slow", 128'(slow_a), 128'(4'b0001));
    chk("any_full_no_ovf", 128'(ovf_a), 128'(0));
    chk("any_full_ovalid", 128'(ovalid_a), 128'(1));
    w = rnd_word();
    chan_data_a[0 +: DW] = w;
    exp_qa.push_back({2'd0, w});
    iready_a = 1'b1;
    tick();
    chan_valid_a = '0;
    chk("pushpop_full_no_ovf", 128'(ovf_a), 128'(0));
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
